// File: rtl/viterbi_pkg.sv
// Shared state type, defaults and address-width helper for the Viterbi
// decoder sequencer.
package viterbi_pkg;

  typedef enum logic [2:0] {IDLE, FILL, FLUSH, TRACE, DONE} vctrl_state_t;

  localparam int DEF_BLK_LEN = 16;
  localparam int DEF_ACS_LAT = 1;

  function automatic int addr_w(input int blk_len);
    return $clog2(blk_len);
  endfunction

endpackage

// File: rtl/vctrl_delay.sv
// Fixed-latency shift register that carries the {valid, addr} write tag
// alongside the ACS pipeline so the survivor write lines up with its data.
module vctrl_delay #(
  parameter int LAT = 1,
  parameter int W   = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data
);

  generate
    if (LAT == 0) begin : g_bypass
      assign o_data = i_data;
    end else begin : g_pipe
      logic [W-1:0] r_stage [LAT];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < LAT; i++) r_stage[i] <= '0;
        end else begin
          r_stage[0] <= i_data;
          for (int i = 1; i < LAT; i++) r_stage[i] <= r_stage[i-1];
        end
      end

      assign o_data = r_stage[LAT-1];
    end
  endgenerate

endmodule

// File: rtl/viterbi_ctrl.sv
// Block sequencer for the Viterbi decoder: symbol intake, ACS strobes,
// survivor write addressing, then a stallable reverse-order traceback.
module viterbi_ctrl
  import viterbi_pkg::*;
#(
  parameter int  BLK_LEN = DEF_BLK_LEN,
  parameter int  ACS_LAT = DEF_ACS_LAT,
  localparam int ADDR_W  = addr_w(BLK_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        rx_pair_in,
  output logic [1:0]        rx_pair,
  output logic              acs_en,
  output logic              acs_init,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic              tb_start,
  output logic              dec_valid,
  input  logic              out_ready,
  output logic              blk_done,
  output logic              busy
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int FL_W  = (ACS_LAT > 1) ? $clog2(ACS_LAT) : 1;
  localparam logic [CNT_W-1:0] LAST_WR    = CNT_W'(BLK_LEN - 1);
  localparam logic [FL_W-1:0]  FLUSH_LAST = FL_W'((ACS_LAT > 0) ? ACS_LAT - 1 : 0);

  vctrl_state_t r_state;
  vctrl_state_t w_state_next;

  logic [CNT_W-1:0]  r_wr_cnt;
  logic [CNT_W-1:0]  r_rd_cnt;
  logic [FL_W-1:0]   r_flush_cnt;
  logic [1:0]        r_rx_pair;
  logic              r_acs_en;
  logic              r_acs_init;
  logic [ADDR_W-1:0] r_acs_idx;
  logic              r_tb_start;
  logic              r_dec_valid;
  logic [ADDR_W-1:0] r_rd_addr_hold;

  logic              w_accept;
  logic              w_flush_end;
  logic              w_rd_en;
  logic              w_last_bit;
  logic [ADDR_W:0]   w_wr_tag;

  assign w_accept    = in_valid & in_ready;
  assign w_flush_end = (r_state == FLUSH) && (r_flush_cnt == FLUSH_LAST);

  // The read counter underflows past address 0; its MSB then marks "all reads issued".
  assign w_rd_en    = (r_state == TRACE) & ~r_tb_start & ~r_rd_cnt[ADDR_W]
                    & (~r_dec_valid | out_ready);
  assign w_last_bit = r_dec_valid & out_ready & r_rd_cnt[ADDR_W];

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    busy         = 1'b1;
    blk_done     = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_state_next = FILL;
      end
      FILL: begin
        in_ready = 1'b1;
        if (in_valid && (r_wr_cnt == LAST_WR)) w_state_next = FLUSH;
      end
      FLUSH: begin
        if (w_flush_end) w_state_next = TRACE;
      end
      TRACE: begin
        if (w_last_bit) w_state_next = DONE;
      end
      DONE: begin
        blk_done     = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_wr_cnt       <= '0;
      r_rd_cnt       <= '0;
      r_flush_cnt    <= '0;
      r_rx_pair      <= '0;
      r_acs_en       <= 1'b0;
      r_acs_init     <= 1'b0;
      r_acs_idx      <= '0;
      r_tb_start     <= 1'b0;
      r_dec_valid    <= 1'b0;
      r_rd_addr_hold <= '0;
    end else begin
      r_state    <= w_state_next;
      r_acs_en   <= w_accept;
      r_acs_init <= w_accept & (r_state == IDLE);

      if (w_accept) begin
        r_rx_pair <= rx_pair_in;
        r_acs_idx <= (r_state == IDLE) ? '0 : r_wr_cnt[ADDR_W-1:0];
        r_wr_cnt  <= (r_state == IDLE) ? CNT_W'(1) : r_wr_cnt + 1'b1;
      end

      r_flush_cnt <= (r_state == FLUSH) ? r_flush_cnt + 1'b1 : '0;
      r_tb_start  <= w_flush_end;

      if (w_flush_end) begin
        r_rd_cnt <= CNT_W'(BLK_LEN - 1);
      end else if (w_rd_en) begin
        r_rd_cnt       <= r_rd_cnt - 1'b1;
        r_rd_addr_hold <= r_rd_cnt[ADDR_W-1:0];
      end

      if (w_rd_en) r_dec_valid <= 1'b1;
      else if (out_ready) r_dec_valid <= 1'b0;
    end
  end

  vctrl_delay #(
    .LAT (ACS_LAT),
    .W   (ADDR_W + 1)
  ) u_wr_delay (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_data ({r_acs_en, r_acs_idx}),
    .o_data (w_wr_tag)
  );

  assign mem_wr_en   = w_wr_tag[ADDR_W];
  assign mem_wr_addr = w_wr_tag[ADDR_W-1:0];

  // While stalled the last issued address stays on the bus.
  assign mem_rd_en   = w_rd_en;
  assign mem_rd_addr = w_rd_en ? r_rd_cnt[ADDR_W-1:0] : r_rd_addr_hold;

  assign rx_pair   = r_rx_pair;
  assign acs_en    = r_acs_en;
  assign acs_init  = r_acs_init;
  assign tb_start  = r_tb_start;
  assign dec_valid = r_dec_valid;

endmodule
